// File: rtl/blink_scheduler.sv
// rtl/blink_scheduler.sv - three-channel LED blink/code scheduler on a shared tick
//
// Purpose: drives three LEDs as OFF, ON, free-running BLINK, or CODE (N pulses
// then a dark gap). All channels advance on one shared prescaled tick.
//
// Ports:
//   clk        clock for all logic
//   rst        synchronous active-high reset
//   cfg_valid  config request valid
//   cfg_ready  high whenever rst is low
//   cfg_chan   target channel 0..2 (3 = invalid, raises cfg_err)
//   cfg_mode   0=OFF 1=ON 2=BLINK 3=CODE
//   cfg_count  pulses per CODE sequence
//   cfg_err    one-cycle pulse after an accepted request to channel 3
//   led_out    registered LED drive, bit n = channel n
//   code_done  one-cycle pulse per channel at the end of each CODE gap
module blink_scheduler #(
  parameter int PRESCALE  = 20800,
  parameter int ON_TICKS  = 20,
  parameter int OFF_TICKS = 20,
  parameter int GAP_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_chan,
  input  logic [1:0] cfg_mode,
  input  logic [3:0] cfg_count,
  output logic       cfg_err,
  output logic [2:0] led_out,
  output logic [2:0] code_done
);

  typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH, GAP} ch_state_t;

  localparam logic [1:0]  MODE_OFF   = 2'd0;
  localparam logic [1:0]  MODE_ON    = 2'd1;
  localparam logic [1:0]  MODE_BLINK = 2'd2;
  localparam logic [1:0]  MODE_CODE  = 2'd3;

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  ON_LEN        = 8'(ON_TICKS);
  localparam logic [7:0]  OFF_LEN       = 8'(OFF_TICKS);
  localparam logic [7:0]  GAP_LEN       = 8'(GAP_TICKS);

  logic [15:0] presc_q, presc_d;
  ch_state_t   state_q [3];
  ch_state_t   state_d [3];
  logic [1:0]  mode_q  [3];
  logic [1:0]  mode_d  [3];
  logic [3:0]  count_q [3];
  logic [3:0]  count_d [3];
  logic [3:0]  pulse_q [3];
  logic [3:0]  pulse_d [3];
  logic [7:0]  phase_q [3];
  logic [7:0]  phase_d [3];
  logic [2:0]  led_q, led_d;
  logic [2:0]  done_q, done_d;
  logic        err_q, err_d;
  logic        tick;
  logic        accept;

  assign cfg_ready = ~rst;
  assign accept    = cfg_valid & cfg_ready;
  assign tick      = (presc_q == PRESCALE_LAST);

  assign led_out   = led_q;
  assign code_done = done_q;
  assign cfg_err   = err_q;

  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    err_d   = accept && (cfg_chan == 2'd3);
    led_d   = led_q;
    done_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      mode_d[i]  = mode_q[i];
      count_d[i] = count_q[i];
      pulse_d[i] = pulse_q[i];
      phase_d[i] = phase_q[i];

      // A config to this channel takes priority over a coincident tick.
      if (accept && (cfg_chan == 2'(i))) begin
        mode_d[i]  = cfg_mode;
        count_d[i] = cfg_count;
        pulse_d[i] = cfg_count;
        phase_d[i] = 8'd0;
        state_d[i] = IDLE;
        led_d[i]   = 1'b0;
        if (cfg_mode == MODE_ON) begin
          led_d[i] = 1'b1;
        end else if ((cfg_mode == MODE_BLINK) ||
                     ((cfg_mode == MODE_CODE) && (cfg_count != 4'd0))) begin
          state_d[i] = ON_PH;
          phase_d[i] = ON_LEN;
          led_d[i]   = 1'b1;
        end
      end else if (tick && (state_q[i] != IDLE)) begin
        if (phase_q[i] != 8'd1) begin
          phase_d[i] = phase_q[i] - 8'd1;
        end else begin
          case (state_q[i])
            ON_PH: begin
              led_d[i] = 1'b0;
              if ((mode_q[i] == MODE_CODE) && (pulse_q[i] == 4'd1)) begin
                pulse_d[i] = 4'd0;
                state_d[i] = GAP;
                phase_d[i] = GAP_LEN;
              end else begin
                if (mode_q[i] == MODE_CODE) begin
                  pulse_d[i] = pulse_q[i] - 4'd1;
                end
                state_d[i] = OFF_PH;
                phase_d[i] = OFF_LEN;
              end
            end
            OFF_PH: begin
              led_d[i]   = 1'b1;
              state_d[i] = ON_PH;
              phase_d[i] = ON_LEN;
            end
            GAP: begin
              done_d[i]  = 1'b1;
              led_d[i]   = 1'b1;
              pulse_d[i] = count_q[i];
              state_d[i] = ON_PH;
              phase_d[i] = ON_LEN;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 16'd0;
      led_q   <= 3'b000;
      done_q  <= 3'b000;
      err_q   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        mode_q[i]  <= MODE_OFF;
        count_q[i] <= 4'd0;
        pulse_q[i] <= 4'd0;
        phase_q[i] <= 8'd0;
      end
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        mode_q[i]  <= mode_d[i];
        count_q[i] <= count_d[i];
        pulse_q[i] <= pulse_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

endmodule

// File: tb/tb_blink_scheduler.sv
// tb/tb_blink_scheduler.sv - self-checking bench for blink_scheduler
module tb_blink_scheduler;

  localparam int PS  = 4;
  localparam int ONT = 2;
  localparam int OFT = 1;
  localparam int GPT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = 2'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] cfg_count = 4'd0;
  logic       cfg_err;
  logic [2:0] led_out;
  logic [2:0] code_done;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model: each channel is described by its mode, count and the
  // number of ticks applied since its last restart; outputs follow from that.
  int       m_pcnt = 0;
  int       m_mode [3] = '{0, 0, 0};
  int       m_cnt  [3] = '{0, 0, 0};
  int       m_t    [3] = '{0, 0, 0};
  logic [2:0] m_led  = 3'b000;
  logic [2:0] m_done = 3'b000;
  logic       m_err  = 1'b0;

  blink_scheduler #(
    .PRESCALE (PS),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFT),
    .GAP_TICKS(GPT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_mode (cfg_mode),
    .cfg_count(cfg_count),
    .cfg_err  (cfg_err),
    .led_out  (led_out),
    .code_done(code_done)
  );

  always #5 clk = ~clk;

  function automatic int code_period(int cnt);
    return cnt * (ONT + OFT) - OFT + GPT;
  endfunction

  function automatic logic model_lit(int mode, int cnt, int t);
    int r;
    case (mode)
      1: return 1'b1;
      2: return (t % (ONT + OFT)) < ONT;
      3: begin
        if (cnt == 0) return 1'b0;
        r = t % code_period(cnt);
        return (r < cnt * (ONT + OFT) - OFT) && ((r % (ONT + OFT)) < ONT);
      end
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_pcnt = 0;
        m_led  = 3'b000;
        m_done = 3'b000;
        m_err  = 1'b0;
        for (int i = 0; i < 3; i++) begin
          m_mode[i] = 0;
          m_cnt[i]  = 0;
          m_t[i]    = 0;
        end
      end else begin
        automatic bit tk = (m_pcnt == PS - 1);
        m_pcnt = tk ? 0 : m_pcnt + 1;
        m_err  = cfg_valid && (cfg_chan == 2'd3);
        for (int i = 0; i < 3; i++) begin
          m_done[i] = 1'b0;
          if (cfg_valid && (int'(cfg_chan) == i)) begin
            m_mode[i] = int'(cfg_mode);
            m_cnt[i]  = int'(cfg_count);
            m_t[i]    = 0;
          end else if (tk) begin
            m_t[i]++;
            if (m_mode[i] == 3 && m_cnt[i] > 0 && (m_t[i] % code_period(m_cnt[i])) == 0)
              m_done[i] = 1'b1;
          end
          m_led[i] = model_lit(m_mode[i], m_cnt[i], m_t[i]);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("led_out",   32'(led_out),   32'(m_led));
        check("code_done", 32'(code_done), 32'(m_done));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
        check("cfg_ready", 32'(cfg_ready), 32'(!rst));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] ch, logic [1:0] md, logic [3:0] cn);
    cfg_valid = v;
    cfg_chan  = ch;
    cfg_mode  = md;
    cfg_count = cn;
  endtask

  // Leave the bench positioned so the next clock edge carries a tick.
  task automatic align_tick();
    for (int k = 0; k <= PS; k++) begin
      if (m_pcnt == PS - 1) return;
      step();
    end
    check("align_tick_timeout", 32'(m_pcnt), 32'(PS - 1));
  endtask

  task automatic write1(logic [1:0] ch, logic [1:0] md, logic [3:0] cn);
    drive(1'b1, ch, md, cn);
    step();
    drive(1'b0, 2'd0, 2'd0, 4'd0);
  endtask

  logic [10:0] code_pat = 11'b00011011011;

  initial begin
    int nz;
    bit found;
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    check("reset_led", 32'(led_out), 32'd0);
    check("reset_ready", 32'(cfg_ready), 32'd0);
    step();
    step();
    rst = 1'b0;

    nz = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (led_out != 3'b000 || code_done != 3'b000 || cfg_err) nz++;
    end
    check("idle_quiet", 32'(nz), 32'd0);

    align_tick();
    write1(2'd0, 2'd2, 4'd0);
    for (int k = 0; k < 24; k++) begin
      check("blink_pattern_ch0", 32'(led_out[0]), 32'((k % 12) < 8));
      step();
    end

    align_tick();
    write1(2'd1, 2'd3, 4'd3);
    for (int k = 0; k < 48; k++) begin
      check("code3_led_ch1", 32'(led_out[1]), 32'(code_pat[(k / 4) % 11]));
      check("code3_done_ch1", 32'(code_done[1]), 32'(k == 44));
      step();
    end

    drive(1'b1, 2'd2, 2'd1, 4'd0);
    step();
    drive(1'b1, 2'd2, 2'd0, 4'd0);
    check("on_then_off_first", 32'(led_out[2]), 32'd1);
    step();
    drive(1'b0, 2'd0, 2'd0, 4'd0);
    check("on_then_off_second", 32'(led_out[2]), 32'd0);
    step();

    write1(2'd3, 2'd2, 4'd5);
    check("err_pulse", 32'(cfg_err), 32'd1);
    step();
    check("err_pulse_end", 32'(cfg_err), 32'd0);
    write1(2'd0, 2'd3, 4'd0);
    check("code0_is_off", 32'(led_out[0]), 32'd0);
    step();

    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if ((m_t[1] % 11) >= 8) found = 1'b1;
      else step();
    end
    check("reach_gap_ch1", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    check("rst_led", 32'(led_out), 32'd0);
    check("rst_done", 32'(code_done), 32'd0);
    step();
    rst = 1'b0;
    nz = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (led_out != 3'b000 || code_done != 3'b000) nz++;
    end
    check("post_rst_dark", 32'(nz), 32'd0);

    align_tick();
    write1(2'd0, 2'd2, 4'd0);
    for (int k = 0; k < 12; k++) begin
      check("tick_coincident_restart", 32'(led_out[0]), 32'(k < 8));
      step();
    end

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom % 60) == 0;
      if (($urandom % 4) == 0)
        drive(1'b1, 2'($urandom % 4), 2'($urandom % 4), 4'($urandom_range(0, 5)));
      else
        drive(1'b0, 2'd0, 2'd0, 4'd0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 2'd0, 4'd0);
    repeat (60) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/blink_scheduler.md
BLINK_SCHEDULER -- requirements
Module: blink_scheduler

Interface
REQ-001 Parameter PRESCALE, default 20800: clk cycles per tick (100 Hz at 2.08 MHz); legal range 2..65535.
REQ-002 Parameter ON_TICKS, default 20: ticks per LED-on phase; legal range 1..255.
REQ-003 Parameter OFF_TICKS, default 20: ticks per LED-off phase between pulses; legal range 1..255.
REQ-004 Parameter GAP_TICKS, default 100: ticks of dark gap after a code sequence; legal range 1..255.
REQ-005 clk  input  1  single clock for all logic; synchronous design, one clock domain.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cfg_valid  input  1  config request valid.
REQ-008 cfg_ready  output  1  scheduler can accept a config request.
REQ-009 cfg_chan  input  2  target channel, 0..2; 3 is invalid.
REQ-010 cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=CODE.
REQ-011 cfg_count  input  4  pulses per CODE sequence; ignored in other modes.
REQ-012 cfg_err  output  1  one-cycle pulse: request with cfg_chan=3 accepted and discarded.
REQ-013 led_out  output  3  registered LED drive, bit n = channel n, 1 = lit.
REQ-014 code_done  output  3  one-cycle pulse per channel at the end of each CODE gap.

Function
REQ-015 Prescaler counts 0..PRESCALE-1 and wraps; the internal tick is high for exactly the one cycle in which the count equals PRESCALE-1.
REQ-016 All three channels share the one prescaler; each channel has its own state (IDLE, ON_PH, OFF_PH, GAP), 8-bit phase counter, 4-bit pulse counter, and stored mode and count.
REQ-017 cfg_ready is 1 in every cycle except while rst is high; a request is accepted on a clock edge where cfg_valid and cfg_ready are both 1.
REQ-018 On acceptance, the addressed channel loads mode and count and restarts; its led_out bit takes the new value in the cycle after the accepting edge (1-cycle latency).
REQ-019 Restart, OFF mode: state IDLE, LED 0.
REQ-020 Restart, ON mode: state IDLE, LED 1.
REQ-021 Restart, CODE mode with cfg_count=0: same as OFF.
REQ-022 Restart, BLINK mode or CODE mode with count>=1: state ON_PH, LED 1, phase counter = ON_TICKS, pulse counter = count.
REQ-023 Phase counters change only on tick; if the counter is 1, the phase ends and the next phase is loaded; otherwise the counter decrements; each phase therefore lasts exactly its parameter in ticks.
REQ-024 BLINK: ON_PH -> OFF_PH (LED 0, OFF_TICKS) -> ON_PH (LED 1, ON_TICKS), repeating indefinitely.
REQ-025 CODE, end of ON_PH: the pulse counter decrements; if the result is nonzero, go to OFF_PH; if zero, go to GAP (LED 0, GAP_TICKS).
REQ-026 CODE, end of OFF_PH: go to ON_PH.
REQ-027 CODE, end of GAP: pulse code_done[n] for that cycle, reload the pulse counter from the stored count, and go to ON_PH.
REQ-028 When an accepted config and a tick coincide on the same channel, the config wins; the channel restarts per REQ-019 to REQ-022 and that tick is not applied to it.
REQ-029 Other channels are unaffected by a config write and continue their sequences on the shared tick.
REQ-030 Requests with cfg_chan=3 change no channel state and raise cfg_err in the next cycle.
REQ-031 Back-to-back accepted requests, one per cycle, are all applied in order.

Reset
REQ-032 While rst is high at a clock edge: prescaler = 0; all channels IDLE with mode OFF, count 0, phase and pulse counters 0.
REQ-033 While rst is high at a clock edge: led_out = 3'b000, code_done = 0, cfg_err = 0, cfg_ready = 0.
REQ-034 rst asserted mid-sequence aborts all channels within that cycle; after release, every LED stays dark until it is reconfigured.

Verification (bench parameters: PRESCALE=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3)
REQ-035 Reset then idle 100 cycles -> led_out=000 throughout; tick every 4th cycle; code_done and cfg_err stay 0.
REQ-036 Write ch0 BLINK -> led_out[0]=1 next cycle; LED stays on for 2 ticks (8 cycles), then alternates on 8 cycles / off 4 cycles.
REQ-037 Write ch1 CODE count=3 -> 3 pulses, each on 8 cycles, separated by 4 cycles off; after the third pulse, 12 cycles dark; code_done[1] pulses once, then the sequence repeats.
REQ-038 Write ch2 ON, then ch2 OFF on the next cycle -> led_out[2] is 1 for one cycle, then 0; ch0/ch1 sequences are unperturbed.
REQ-039 Write cfg_chan=3 -> cfg_err pulses once; led_out unchanged. Write ch0 CODE count=0 -> led_out[0]=0.
REQ-040 Assert rst in mid-GAP of ch1 -> led_out=000 and no code_done; after release, all LEDs stay 0 until new writes; a write in the same cycle as a tick restarts that channel's ON_PH at the full 2 ticks.
